c880_vector_harness: RTL and testbench
======================================

Name: c880_vector_harness

Overview:
- Sequential stimulus/response stage wrapped around the combinational c880 benchmark netlist.
- Upstream: accepts 60-bit test vectors over a valid/ready handshake and drives them, registered, onto the c880 primary inputs.
- Downstream: holds each vector for a programmable settle time, then captures the 26 c880 primary outputs and returns them over a second valid/ready handshake.
- Maintains a vector counter and an optional MISR signature for gate-level regression of generated netlists.

Parameters:
- SETTLE_CYC, 2, cycles spent in APPLY before capture; legal range 1..255.
- COUNT_W, 16, width of vec_count.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- vec_valid  in  1  upstream vector valid
- vec_ready  out  1  harness can accept a vector
- vec_data  in  60  c880 primary inputs in declaration order; bit0=N1 … bit59=N268
- pi_o  out  60  registered drive to the c880 inputs, same bit order
- po_i  in  26  c880 outputs in declaration order; bit0=N388 … bit25=N880
- resp_valid  out  1  captured response valid
- resp_ready  in  1  downstream accepts response
- resp_data  out  26  captured po_i
- clear  in  1  synchronous clear of vec_count and sig_o
- busy  out  1  state != IDLE
- vec_count  out  COUNT_W  number of vectors captured, saturating
- sig_o  out  26  MISR signature (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; pi_o=0, resp_valid=0, resp_data=0, vec_count=0, sig_o=0, busy=0, vec_ready=1.
- vec_ready = (state==IDLE), combinational. Only one vector is in flight at a time.
- IDLE:
  - On vec_valid&&vec_ready at edge E0: pi_o<=vec_data, cnt<=SETTLE_CYC-1, go to APPLY.
  - Otherwise hold.
- APPLY:
  - Each edge: if cnt==0, go to CAPTURE; else cnt<=cnt-1.
  - pi_o stays constant; vec_valid is ignored.
- CAPTURE (one cycle):
  - resp_data<=po_i, resp_valid<=1.
  - vec_count<=vec_count+1, saturating at all-ones.
  - MISR update.
  - Go to RESP.
- Latency: resp_valid rises at edge E0+SETTLE_CYC+1 (E0+3 at default).
- RESP:
  - resp_valid and resp_data are held stable until resp_valid&&resp_ready.
  - On that edge: resp_valid<=0, go to IDLE.
  - A new vector can be accepted on the following cycle, not the same edge.
- pi_o keeps the last applied vector after returning to IDLE; it is never cleared except by reset.
- clear:
  - Honoured in every state.
  - Sets vec_count=0 and sig_o=0 on the next edge.
  - If clear coincides with the CAPTURE edge, clear wins: count=0, sig=0.
  - resp_data/resp_valid are still produced normally.
- Reset asserted mid-operation aborts immediately to the reset values; any partially applied vector is discarded.
- po_i is sampled only on the CAPTURE edge and is don't-care in every other state.

Optional Feature:
- Macro: C880_MISR_EN.
- Defined:
  - 26-bit Galois MISR, polynomial x^26+x^6+x^2+x+1.
  - On CAPTURE: t = {sig_o[24:0],1'b0} ^ (sig_o[25] ? 26'h0000047 : 0); sig_o <= t ^ po_i.
  - Cleared by reset and by clear.
- Not defined: sig_o is tied to 0, and no MISR registers are synthesised.

Test Plan:
- Reset check: drive rst_n low for 3 cycles with random inputs -> all outputs at reset values, vec_ready=1, busy=0.
- Basic flow, SETTLE_CYC=2:
  - Stimulus: accept vec_data=60'h0 at E0, model drives po_i=26'h155_5555, resp_ready=1.
  - Response: resp_valid high at E0+3 only; resp_data=26'h1555555; vec_count=1; vec_ready back to 1 at E0+4.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 5 cycles after resp_valid, with vec_valid=1 throughout.
  - Response: resp_data stable, vec_ready=0, no second accept; after resp_ready=1, IDLE then accept on the next edge.
- MISR (C880_MISR_EN):
  - Two captures of po_i=26'h0000001 from sig 0 -> sig_o=0x0000001, then 0x0000003.
  - Preload via captures to sig_o=26'h2000000, then capture po_i=0 -> sig_o=26'h0000047.
- Saturation/clear, COUNT_W=4:
  - 17 vectors -> vec_count=15.
  - Assert clear on the CAPTURE edge of an 18th vector -> vec_count=0, sig_o=0, resp_valid still asserted.
- Async reset mid-APPLY: drop rst_n between edges during APPLY -> outputs zero immediately (no clock edge needed), state IDLE, no resp_valid after release.

Source files
------------

// File: rtl/c880_vector_harness.sv
// c880_vector_harness: registered stimulus/response wrapper around the
// combinational c880 netlist. A single vector is accepted, driven onto the
// c880 inputs for SETTLE_CYC cycles, then the c880 outputs are captured and
// returned over a valid/ready handshake. A saturating count of captured
// vectors is kept.
//
// Optional feature macro: C880_MISR_EN
//   defined   -> 26-bit Galois MISR (x^26+x^6+x^2+x+1) folds each captured
//                response into sig_o.
//   undefined -> sig_o is tied to zero and no MISR flops exist.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a vector; vec_ready high
// APPLY   | vector held on pi_o, settle counter running down to zero
// CAPTURE | one cycle; po_i sampled into resp_data on the leaving edge
// RESP    | resp_valid high, waiting for resp_ready
module c880_vector_harness #(
  parameter int SETTLE_CYC = 2,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [59:0]        vec_data,
  output logic [59:0]        pi_o,
  input  logic [25:0]        po_i,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [25:0]        resp_data,
  input  logic               clear,
  output logic               busy,
  output logic [COUNT_W-1:0] vec_count,
  output logic [25:0]        sig_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Settle counter is 8 bits wide because SETTLE_CYC is limited to 1..255.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [59:0]        pi_q, pi_d;
  logic               resp_valid_q, resp_valid_d;
  logic [25:0]        resp_data_q, resp_data_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Next-state and datapath updates; clear overrides the count last so it
  // wins over a coincident capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pi_d         = pi_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    count_d      = count_q;
    unique case (state_q)
      IDLE: begin
        if (vec_valid) begin
          pi_d    = vec_data;
          cnt_d   = SETTLE_LOAD;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == 8'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CAPTURE: begin
        resp_data_d  = po_i;
        resp_valid_d = 1'b1;
        if (count_q != {COUNT_W{1'b1}}) begin
          count_d = count_q + COUNT_W'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      count_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pi_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pi_q         <= pi_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      count_q      <= count_d;
    end
  end

`ifdef C880_MISR_EN
  localparam logic [25:0] MISR_TAPS = 26'h0000047;

  logic [25:0] sig_q, sig_d, sig_shift;

  // MISR fold on the capture edge; clear takes priority.
  always_comb begin
    sig_shift = {sig_q[24:0], 1'b0} ^ (sig_q[25] ? MISR_TAPS : 26'h0);
    sig_d     = sig_q;
    if (state_q == CAPTURE) begin
      sig_d = sig_shift ^ po_i;
    end
    if (clear) begin
      sig_d = '0;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;
`else
  assign sig_o = 26'h0;
`endif

  assign vec_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign pi_o       = pi_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign vec_count  = count_q;

endmodule

// File: tb/tb_c880_vector_harness.sv
// Testbench for c880_vector_harness (SETTLE_CYC=2, COUNT_W=4).
// Reference model tracks the expected vector count and signature as plain
// numbers; expected latency is SETTLE_CYC+1 edges from acceptance.
module tb_c880_vector_harness;

  localparam int SETTLE = 2;
  localparam int CW     = 4;
  localparam int MAXC   = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vec_valid;
  logic          vec_ready;
  logic [59:0]   vec_data;
  logic [59:0]   pi_o;
  logic [25:0]   po_i;
  logic          resp_valid;
  logic          resp_ready;
  logic [25:0]   resp_data;
  logic          clear;
  logic          busy;
  logic [CW-1:0] vec_count;
  logic [25:0]   sig_o;

  int checks = 0;
  int errors = 0;
  int m_count = 0;
  logic [25:0] m_sig = 26'h0;

  c880_vector_harness #(.SETTLE_CYC(SETTLE), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .pi_o(pi_o), .po_i(po_i), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .clear(clear),
    .busy(busy), .vec_count(vec_count), .sig_o(sig_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [59:0] rand60();
    return 60'({$urandom(), $urandom()});
  endfunction

`ifdef C880_MISR_EN
  // Multiply the signature polynomial by x modulo x^26+x^6+x^2+x+1, then add data.
  function automatic logic [25:0] misr_next(logic [25:0] s, logic [25:0] d);
    longint v;
    longint top;
    v   = longint'(s);
    top = (v >> 25) & 1;
    v   = (v * 2) % (longint'(1) << 26);
    if (top == 1) v = v ^ 'h47;
    return 26'(v) ^ d;
  endfunction
`endif

  task automatic model_capture(input logic [25:0] po, input bit clr);
    if (clr) begin
      m_count = 0;
      m_sig   = 26'h0;
    end else begin
      if (m_count < MAXC) m_count++;
`ifdef C880_MISR_EN
      m_sig = misr_next(m_sig, po);
`endif
    end
  endtask

  // Offer one vector from IDLE, wait (bounded) for resp_valid; lat is the
  // number of edges after the accept edge, 20 on timeout.
  task automatic send_vec(input logic [59:0] v, input logic [25:0] po,
                          input bit clr_cap, output int lat);
    vec_valid  = 1'b1;
    vec_data   = v;
    po_i       = po;
    resp_ready = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      vec_valid = 1'($urandom_range(0, 1));
      vec_data  = rand60();
      if (lat == SETTLE) clear = clr_cap;
      @(negedge clk);
      lat++;
      clear = 1'b0;
    end
    vec_valid = 1'b0;
    model_capture(po, clr_cap);
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_valid  = 1'($urandom_range(0, 1));
      vec_data   = rand60();
      po_i       = 26'($urandom());
      resp_ready = 1'($urandom_range(0, 1));
      clear      = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++; if (pi_o !== 60'h0) begin errors++; $display("FAIL reset_pi: got %h expected 0", pi_o); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_data !== 26'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    checks++; if (vec_count !== 4'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", vec_count); end
    checks++; if (sig_o !== 26'h0) begin errors++; $display("FAIL reset_sig: got %h expected 0", sig_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (vec_ready !== 1'b1) begin errors++; $display("FAIL reset_vec_ready: got %b expected 1", vec_ready); end
    vec_valid  = 1'b0;
    resp_ready = 1'b0;
    clear      = 1'b0;
    rst_n      = 1'b1;
    m_count    = 0;
    m_sig      = 26'h0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    send_vec(60'h0, 26'h1555555, 1'b0, lat);
    checks++; if (lat !== SETTLE + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, SETTLE + 1); end
    checks++; if (resp_data !== 26'h1555555) begin errors++; $display("FAIL basic_resp_data: got %h expected 1555555", resp_data); end
    checks++; if (vec_count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", vec_count); end
    checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_resp: got %b expected 0", vec_ready); end
    release_resp();
    checks++; if (vec_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_back_to_idle: ready %b valid %b busy %b expected 1 0 0", vec_ready, resp_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    logic [59:0] v, v2;
    logic [25:0] po, po2;
    v  = rand60();
    po = 26'($urandom());
    send_vec(v, po, 1'b0, lat);
    checks++; if (lat !== SETTLE + 1) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, SETTLE + 1); end
    vec_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vec_data = rand60();
      po_i     = 26'($urandom());
      @(negedge clk);
      if (resp_data !== po || resp_valid !== 1'b1 || vec_ready !== 1'b0 || pi_o !== v) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin
      errors++; $display("FAIL bp_hold: data %h valid %b ready %b pi %h expected %h 1 0 %h", resp_data, resp_valid, vec_ready, pi_o, po, v);
    end
    v2 = rand60();
    vec_data   = v2;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || vec_ready !== 1'b1 || pi_o !== v) begin
      errors++; $display("FAIL bp_release: valid %b ready %b pi %h expected 0 1 %h", resp_valid, vec_ready, pi_o, v);
    end
    po2  = 26'($urandom());
    po_i = po2;
    @(negedge clk);
    vec_valid = 1'b0;
    checks++; if (busy !== 1'b1 || pi_o !== v2) begin
      errors++; $display("FAIL bp_next_accept: busy %b pi %h expected 1 %h", busy, pi_o, v2);
    end
    lat = 0;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    model_capture(po2, 1'b0);
    checks++; if (lat !== SETTLE + 1 || resp_data !== po2) begin
      errors++; $display("FAIL bp_second_resp: lat %0d data %h expected %0d %h", lat, resp_data, SETTLE + 1, po2);
    end
    checks++; if (vec_count !== CW'(m_count)) begin errors++; $display("FAIL bp_count: got %0d expected %0d", vec_count, m_count); end
    release_resp();
  endtask

  task automatic test_random();
    int lat;
    logic [59:0] v;
    logic [25:0] po;
    for (int n = 0; n < 6; n++) begin
      v  = rand60();
      po = 26'($urandom());
      send_vec(v, po, 1'b0, lat);
      checks++; if (lat !== SETTLE + 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, lat, SETTLE + 1); end
      checks++; if (resp_data !== po) begin errors++; $display("FAIL rnd_resp_data[%0d]: got %h expected %h", n, resp_data, po); end
      checks++; if (vec_count !== CW'(m_count)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, vec_count, m_count); end
      checks++; if (sig_o !== m_sig) begin errors++; $display("FAIL rnd_sig[%0d]: got %h expected %h", n, sig_o, m_sig); end
      checks++; if (pi_o !== v) begin errors++; $display("FAIL rnd_pi[%0d]: got %h expected %h", n, pi_o, v); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_resp();
      checks++; if (vec_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected 1", n, vec_ready); end
    end
  endtask

  task automatic test_misr();
    int lat;
    logic [25:0] e1, e2, e3, e4;
`ifdef C880_MISR_EN
    e1 = 26'h0000001; e2 = 26'h0000003; e3 = 26'h2000000; e4 = 26'h0000047;
`else
    e1 = 26'h0; e2 = 26'h0; e3 = 26'h0; e4 = 26'h0;
`endif
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_count = 0;
    m_sig   = 26'h0;
    checks++; if (vec_count !== 4'd0 || sig_o !== 26'h0) begin
      errors++; $display("FAIL misr_clear_idle: count %0d sig %h expected 0 0", vec_count, sig_o);
    end
    send_vec(rand60(), 26'h0000001, 1'b0, lat);
    checks++; if (sig_o !== e1) begin errors++; $display("FAIL misr_first: got %h expected %h", sig_o, e1); end
    release_resp();
    send_vec(rand60(), 26'h0000001, 1'b0, lat);
    checks++; if (sig_o !== e2) begin errors++; $display("FAIL misr_second: got %h expected %h", sig_o, e2); end
    release_resp();
    send_vec(rand60(), 26'h2000006, 1'b0, lat);
    checks++; if (sig_o !== e3) begin errors++; $display("FAIL misr_preload: got %h expected %h", sig_o, e3); end
    release_resp();
    send_vec(rand60(), 26'h0000000, 1'b0, lat);
    checks++; if (sig_o !== e4) begin errors++; $display("FAIL misr_feedback: got %h expected %h", sig_o, e4); end
    checks++; if (vec_count !== CW'(m_count)) begin errors++; $display("FAIL misr_count: got %0d expected %0d", vec_count, m_count); end
    release_resp();
  endtask

  task automatic test_saturation();
    int lat;
    logic [25:0] po;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_count = 0;
    m_sig   = 26'h0;
    for (int n = 0; n < 17; n++) begin
      send_vec(rand60(), 26'($urandom()), 1'b0, lat);
      release_resp();
    end
    checks++; if (vec_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", vec_count); end
    checks++; if (sig_o !== m_sig) begin errors++; $display("FAIL sat_sig: got %h expected %h", sig_o, m_sig); end
    po = 26'($urandom()) | 26'h1;
    send_vec(rand60(), po, 1'b1, lat);
    checks++; if (lat !== SETTLE + 1 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL clr_cap_valid: lat %0d valid %b expected %0d 1", lat, resp_valid, SETTLE + 1);
    end
    checks++; if (resp_data !== po) begin errors++; $display("FAIL clr_cap_data: got %h expected %h", resp_data, po); end
    checks++; if (vec_count !== 4'd0 || sig_o !== 26'h0) begin
      errors++; $display("FAIL clr_cap_wins: count %0d sig %h expected 0 0", vec_count, sig_o);
    end
    release_resp();
  endtask

  task automatic test_async_reset();
    bit seen;
    vec_valid = 1'b1;
    vec_data  = rand60() | 60'h1;
    po_i      = 26'($urandom());
    @(negedge clk);
    vec_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_in_apply: busy %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    m_count = 0;
    m_sig   = 26'h0;
    checks++; if (pi_o !== 60'h0 || busy !== 1'b0 || vec_ready !== 1'b1) begin
      errors++; $display("FAIL arst_immediate: pi %h busy %b ready %b expected 0 0 1", pi_o, busy, vec_ready);
    end
    checks++; if (resp_valid !== 1'b0 || vec_count !== 4'd0 || sig_o !== 26'h0 || resp_data !== 26'h0) begin
      errors++; $display("FAIL arst_outputs: valid %b count %0d sig %h data %h expected all 0", resp_valid, vec_count, sig_o, resp_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL arst_no_resume: valid %b busy %b expected 0 0", resp_valid, busy); end
  endtask

  initial begin
    rst_n      = 1'b0;
    vec_valid  = 1'b0;
    vec_data   = 60'h0;
    po_i       = 26'h0;
    resp_ready = 1'b0;
    clear      = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_misr();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
